// File: rtl/i2c_lm75_pkg.sv
// Shared types and constants for the LM75-class I2C temperature sensor target.
package i2c_lm75_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } state_e;

  localparam logic [1:0] PTR_TEMP  = 2'd0;
  localparam logic [1:0] PTR_CONF  = 2'd1;
  localparam logic [1:0] PTR_THYST = 2'd2;
  localparam logic [1:0] PTR_TOS   = 2'd3;

  localparam int unsigned CfgShutdown = 0;
  localparam int unsigned CfgIntMode  = 1;
  localparam int unsigned CfgPolarity = 2;
  localparam int unsigned CfgFaultLo  = 3;

  // Config[4:3] selects how many consecutive over-limit samples trip OS.
  function automatic logic [2:0] fault_depth(input logic [1:0] sel);
    unique case (sel)
      2'd0:    fault_depth = 3'd1;
      2'd1:    fault_depth = 3'd2;
      2'd2:    fault_depth = 3'd4;
      default: fault_depth = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers with registered edge and START/STOP pulses.
// Every pulse and level output lags the pad by three clk_i cycles.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_q, sda_q;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  // Two-flop synchronisers, one history stage, registered event detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_q      <= scl_sync_q[1];
      sda_q      <= sda_sync_q[1];
      scl_rise_q <= scl_sync_q[1] & ~scl_q;
      scl_fall_q <= ~scl_sync_q[1] & scl_q;
      start_q    <= scl_sync_q[1] & scl_q & ~sda_sync_q[1] & sda_q;
      stop_q     <= scl_sync_q[1] & scl_q & sda_sync_q[1] & ~sda_q;
    end
  end

  assign sda_o      = sda_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_temp_sensor_slave.sv
// LM75-class I2C temperature sensor target (Temp, Config, Thyst, Tos).
// Define OS_OUT_EN to build the overtemperature comparator and the Os pin.
module i2c_temp_sensor_slave
  import i2c_lm75_pkg::*;
#(
  parameter logic [6:0]  ADDR      = 7'h48,
  parameter int unsigned TEMP_BITS = 9,
  parameter logic [15:0] THYST_RST = 16'h4B00,
  parameter logic [15:0] TOS_RST   = 16'h5000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Scl_in,
  input  logic                 Sda_in,
  output logic                 Sda_oe,
  input  logic [TEMP_BITS-1:0] Temp_in,
  input  logic                 Temp_valid,
  output logic                 Busy
`ifdef OS_OUT_EN
  ,
  output logic                 Os
`endif
);

  localparam int unsigned PadBits = 16 - TEMP_BITS;

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_sync u_sync (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .scl_i      (Scl_in),
    .sda_i      (Sda_in),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q, tx_q;
  logic        rw_q, busy_q, sda_oe_q, ack_q, rd_lsb_q, wr_lsb_q;
  logic [1:0]  ptr_q;
  logic [7:0]  cfg_q, wr_msb_q, rd_byte;
  logic [15:0] temp_q, thyst_q, tos_q, shadow_q, temp_aligned;
  logic [7:0]  byte_in;
  logic        rd_load, sample;

  assign byte_in      = {shift_q, sda};
  assign temp_aligned = {Temp_in, {PadBits{1'b0}}};
  assign sample       = Temp_valid & ~cfg_q[CfgShutdown];
  // Start of every read byte: after the address ACK or a master ACK.
  assign rd_load = !start && !stop && scl_fall &&
                   ((state_q == StAddrAck && sda_oe_q && rw_q) ||
                    (state_q == StRdAck && ack_q));

  // Byte presented for the next read; Temp MSB comes live, Temp LSB from the shadow.
  always_comb begin
    rd_byte = 8'h00;
    unique case (ptr_q)
      PTR_TEMP:  rd_byte = rd_lsb_q ? shadow_q[7:0] : temp_q[15:8];
      PTR_CONF:  rd_byte = cfg_q;
      PTR_THYST: rd_byte = rd_lsb_q ? thyst_q[7:0] : thyst_q[15:8];
      default:   rd_byte = rd_lsb_q ? tos_q[7:0] : tos_q[15:8];
    endcase
  end

  // Bus protocol FSM and register file writes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      tx_q      <= 7'd0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      ack_q     <= 1'b0;
      rd_lsb_q  <= 1'b0;
      wr_lsb_q  <= 1'b0;
      ptr_q     <= PTR_TEMP;
      cfg_q     <= 8'h00;
      wr_msb_q  <= 8'h00;
      thyst_q   <= THYST_RST;
      tos_q     <= TOS_RST;
      shadow_q  <= 16'h0000;
    end else if (start) begin
      state_q   <= StAddr;
      bit_cnt_q <= 3'd0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else if (stop) begin
      state_q  <= StIdle;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else if (rd_load) begin
      state_q  <= StRdData;
      tx_q     <= rd_byte[6:0];
      sda_oe_q <= ~rd_byte[7];
      rd_lsb_q <= ~rd_lsb_q;
      ack_q    <= 1'b0;
      if (!rd_lsb_q) shadow_q <= temp_q;
    end else begin
      if (scl_rise) shift_q <= byte_in[6:0];
      unique case (state_q)
        StAddr: if (scl_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_in[7:1] == ADDR) begin
              state_q  <= StAddrAck;
              rw_q     <= byte_in[0];
              busy_q   <= 1'b1;
              rd_lsb_q <= 1'b0;
            end else begin
              state_q <= StIgnore;
            end
          end
        end
        // ACK states drive low on the first falling edge and release on the next.
        StAddrAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_q <= 1'b1;
          end else begin
            sda_oe_q <= 1'b0;
            state_q  <= StPtr;
          end
        end
        StPtr: if (scl_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_q   <= byte_in[1:0];
            state_q <= StPtrAck;
          end
        end
        StPtrAck, StWrAck: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_q <= 1'b1;
          end else begin
            sda_oe_q <= 1'b0;
            if (state_q == StPtrAck) wr_lsb_q <= 1'b0;
            state_q <= StWrData;
          end
        end
        StWrData: if (scl_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_q  <= StWrAck;
            wr_lsb_q <= ~wr_lsb_q;
            if (ptr_q == PTR_CONF) cfg_q <= byte_in;
            if (!wr_lsb_q) wr_msb_q <= byte_in;
            else if (ptr_q == PTR_THYST) thyst_q <= {wr_msb_q, byte_in};
            else if (ptr_q == PTR_TOS) tos_q <= {wr_msb_q, byte_in};
          end
        end
        StRdData: begin
          if (scl_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StRdAck;
          end else if (scl_fall) begin
            sda_oe_q <= ~tx_q[~bit_cnt_q];
          end
        end
        StRdAck: begin
          if (scl_fall) sda_oe_q <= 1'b0;
          else if (scl_rise) begin
            if (sda) state_q <= StIgnore;
            else ack_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Temperature register; samples are dropped while in shutdown.
  always_ff @(posedge Clk) begin
    if (Rst) temp_q <= 16'h0000;
    else if (sample) temp_q <= temp_aligned;
  end

  assign Sda_oe = sda_oe_q & ~Rst;
  assign Busy   = busy_q;

`ifdef OS_OUT_EN
  logic [2:0] fault_cnt_q;
  logic       os_act_q, os_armed_q;
  logic       over, under;

  assign over  = $signed(temp_aligned) > $signed(tos_q);
  assign under = $signed(temp_aligned) < $signed(thyst_q);

  // Fault queue and OS state; armed marks an interrupt-mode event awaiting Thyst.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fault_cnt_q <= 3'd0;
      os_act_q    <= 1'b0;
      os_armed_q  <= 1'b0;
    end else begin
      if (sample) begin
        if (over) begin
          if (fault_cnt_q < 3'd6) fault_cnt_q <= fault_cnt_q + 3'd1;
          if ((fault_cnt_q + 3'd1) >= fault_depth(cfg_q[CfgFaultLo+:2]) && !os_armed_q) begin
            os_act_q   <= 1'b1;
            os_armed_q <= cfg_q[CfgIntMode];
          end
        end else begin
          fault_cnt_q <= 3'd0;
          if (under) begin
            if (!cfg_q[CfgIntMode]) begin
              os_act_q <= 1'b0;
            end else if (os_armed_q) begin
              os_act_q   <= 1'b1;
              os_armed_q <= 1'b0;
            end
          end
        end
      end
      if (cfg_q[CfgIntMode] && rd_load) os_act_q <= 1'b0;
    end
  end

  assign Os = cfg_q[CfgPolarity] ? os_act_q : ~os_act_q;
`endif

endmodule
